// File: rtl/noc_echo_responder_pkg.sv
// Shared NoC header layout and header helpers, reused by the NoC endpoints.
package noc_echo_responder_pkg;

  localparam int DEST_W  = 5;
  localparam int CLASS_W = 3;
  localparam int SRC_W   = 5;
  localparam int HDR_W   = DEST_W + CLASS_W + SRC_W;

  // hdr is the top HDR_W bits of a header flit: {dest, class, src}.
  // The reply goes back to the sender and carries our own ID as source.
  function automatic logic [HDR_W-1:0] swap_hdr(input logic [HDR_W-1:0] hdr,
                                                input logic [SRC_W-1:0] own_id);
    return {hdr[SRC_W-1:0], hdr[SRC_W+CLASS_W-1:SRC_W], own_id};
  endfunction

endpackage

// File: rtl/noc_pkt_buffer.sv
// Single-packet flit store: register array with one write port, one
// asynchronous read port and its own write/read pointers.
module noc_pkt_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_clr,
  input  logic [FLIT_WIDTH-1:0] wr_data,
  input  logic                  rd_inc,
  input  logic                  rd_clr,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic [FLIT_WIDTH-1:0] rd_data
);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // A clear wins over an increment: the final flit is still written, then
  // the pointer restarts for the next packet.
  always_ff @(posedge clk) begin
    if (rst || wr_clr) wr_ptr <= '0;
    else if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || rd_clr) rd_ptr <= '0;
    else if (rd_inc)   rd_ptr <= rd_ptr + 1'b1;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/noc_echo_responder.sv
// NoC endpoint that buffers one packet at a time and echoes it back to the
// tile with the header's destination and source swapped.
//
// state | meaning
// RX    | accepting flits of a packet into the buffer
// TX    | echoing the buffered packet, input stalled
// DROP  | packet too long for the buffer, discarding until its last flit
module noc_echo_responder
  import noc_echo_responder_pkg::*;
#(
  parameter int FLIT_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 8,
  parameter int ID          = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  echo_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int PTR_W = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_PKT_LEN - 1);
  localparam logic [SRC_W-1:0] OWN_ID    = SRC_W'(ID);

  typedef enum logic [1:0] {RX, TX, DROP} state_t;

  state_t state, state_nxt;

  logic                  wr_en, wr_clr, rd_inc, rd_clr;
  logic                  len_ld, echo_inc, drop_inc;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W-1:0]      last_idx;
  logic [FLIT_WIDTH-1:0] rd_data;
  logic                  is_last;

  noc_pkt_buffer #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .DEPTH      (MAX_PKT_LEN),
    .PTR_W      (PTR_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_clr  (wr_clr),
    .wr_data (in_flit),
    .rd_inc  (rd_inc),
    .rd_clr  (rd_clr),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RX;
    else     state <= state_nxt;
  end

  // Packet length is kept as the index of its last flit (len-1).
  always_ff @(posedge clk) begin
    if (rst)         last_idx <= '0;
    else if (len_ld) last_idx <= wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (echo_inc) echo_cnt <= echo_cnt + 1'b1;
      if (drop_inc) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign is_last = (rd_ptr == last_idx);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_clr    = 1'b0;
    rd_inc    = 1'b0;
    rd_clr    = 1'b0;
    len_ld    = 1'b0;
    echo_inc  = 1'b0;
    drop_inc  = 1'b0;
    unique case (state)
      RX: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_last) begin
            len_ld    = 1'b1;
            wr_clr    = 1'b1;
            state_nxt = TX;
          end else if (wr_ptr == LAST_SLOT) begin
            wr_clr    = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          drop_inc  = 1'b1;
          state_nxt = RX;
        end
      end
      TX: begin
        if (out_ready) begin
          rd_inc = 1'b1;
          if (is_last) begin
            rd_clr    = 1'b1;
            echo_inc  = 1'b1;
            state_nxt = RX;
          end
        end
      end
      default: state_nxt = RX;
    endcase
  end

  // Outputs come straight from registered state and the buffer, so they stay
  // stable for as long as the tile stalls.
  assign out_valid = (state == TX);
  assign out_last  = out_valid && is_last;

  always_comb begin
    out_flit = '0;
    if (out_valid) begin
      if (rd_ptr == '0)
        out_flit = {swap_hdr(rd_data[FLIT_WIDTH-1 -: HDR_W], OWN_ID),
                    rd_data[FLIT_WIDTH-HDR_W-1:0]};
      else
        out_flit = rd_data;
    end
  end

endmodule

// File: tb/tb_noc_echo_responder.sv
// Scoreboard bench for noc_echo_responder: driver pushes expected echoes,
// a negedge monitor pops and compares every transferred output flit.
module tb_noc_echo_responder;

  localparam int FW   = 32;
  localparam int MAXL = 8;
  localparam int ID   = 0;
  localparam int CW   = 16;

  logic          clk;
  logic          rst;
  logic [FW-1:0] in_flit;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] echo_cnt;
  logic [CW-1:0] drop_cnt;

  noc_echo_responder #(
    .FLIT_WIDTH  (FW),
    .MAX_PKT_LEN (MAXL),
    .ID          (ID),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .echo_cnt  (echo_cnt),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] flit;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;

  logic [FW-1:0] pa [16];
  logic [FW-1:0] pb [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Echo header: dest takes old src, src becomes ID, class/payload kept.
  function automatic logic [FW-1:0] echo_hdr(input logic [FW-1:0] f);
    logic [FW-1:0] src;
    src = (f >> 19) & 32'h1F;
    return (f & 32'h0707_FFFF) | (src << 27) | (32'(ID) << 19);
  endfunction

  logic [FW-1:0] prev_flit;
  logic          prev_last;
  logic          prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_flit", out_flit, prev_flit);
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h last %0b expected no output", out_flit, out_last);
        end else begin
          e = exp_q.pop_front();
          check("echo_flit", out_flit, e.flit);
          check("echo_last", 32'(out_last), 32'(e.last));
        end
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_flit  = out_flit;
      prev_last  = out_last;
    end
  end

  // Called and returns at posedge+1; returns once the last flit is accepted.
  task automatic send_pkt(input logic [FW-1:0] f [16], input int n, input bit push_exp);
    exp_t e;
    bit   rdy;
    int   cyc;
    if (push_exp) begin
      for (int i = 0; i < n; i++) begin
        e.flit = (i == 0) ? echo_hdr(f[0]) : f[i];
        e.last = (i == n - 1);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_flit  = f[i];
      in_last  = (i == n - 1);
      cyc = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        cyc++;
      end while (!rdy && cyc < 100);
      if (!rdy) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", cyc);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_flit  = '0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d flits outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int n0;
    int cyc;
    rst       = 1'b1;
    in_flit   = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_flit", out_flit, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_echo_cnt", 32'(echo_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // 1: three-flit packet, header hand-swapped (dest 3 -> 16, src 16 -> 0)
    pa[0] = 32'h1A84_0001; pa[1] = 32'hDEAD_BEEF; pa[2] = 32'h0000_0005;
    exp_q.push_back('{flit: 32'h8204_0001, last: 1'b0});
    exp_q.push_back('{flit: 32'hDEAD_BEEF, last: 1'b0});
    exp_q.push_back('{flit: 32'h0000_0005, last: 1'b1});
    send_pkt(pa, 3, 1'b0);
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    check("t1_tx_in_ready", 32'(in_ready), 32'd0);
    wait_drain("t1");
    check("t1_echo_cnt", 32'(echo_cnt), 32'd1);

    // 2: backpressure mid-echo
    pa[0] = 32'h2B10_1234; pa[1] = 32'h1111_1111; pa[2] = 32'h2222_2222; pa[3] = 32'h3333_3333;
    out_ready = 1'b0;
    send_pkt(pa, 4, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("t2_stall_in_ready", 32'(in_ready), 32'd0);
      check("t2_stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    wait_drain("t2");
    check("t2_echo_cnt", 32'(echo_cnt), 32'd2);

    // 3: oversize packet dropped, then a short packet still echoes
    for (int i = 0; i < 10; i++) pa[i] = 32'hC000_0000 + 32'(i);
    send_pkt(pa, 10, 1'b0);
    check("t3_no_valid", 32'(out_valid), 32'd0);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t3_echo_cnt_hold", 32'(echo_cnt), 32'd2);
    pb[0] = 32'h4D2A_BCDE; pb[1] = 32'h0BAD_F00D;
    send_pkt(pb, 2, 1'b1);
    wait_drain("t3");
    check("t3_echo_cnt", 32'(echo_cnt), 32'd3);

    // 4: back-to-back 1-flit and full-length packets
    do_reset();
    pa[0] = 32'h6F38_0042;
    send_pkt(pa, 1, 1'b1);
    check("t4_single_last", 32'(out_last), 32'd1);
    pb[0] = 32'h5A9C_0010;
    for (int i = 1; i < MAXL; i++) pb[i] = 32'hA5A5_0000 + 32'(i);
    send_pkt(pb, MAXL, 1'b1);
    wait_drain("t4");
    check("t4_echo_cnt", 32'(echo_cnt), 32'd2);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd0);

    // 5: reset on the second echo flit
    pa[0] = 32'h0F50_0007; pa[1] = 32'h7777_0001; pa[2] = 32'h7777_0002;
    send_pkt(pa, 3, 1'b1);
    n0 = xfer_cnt;
    cyc = 0;
    while (xfer_cnt < n0 + 1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_second_flit", out_flit, 32'h7777_0001);
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_echo_cnt", 32'(echo_cnt), 32'd0);
    check("t5_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    pb[0] = 32'h3E68_0099; pb[1] = 32'h1234_5678;
    send_pkt(pb, 2, 1'b1);
    wait_drain("t5");
    check("t5_echo_cnt", 32'(echo_cnt), 32'd1);

    // 6: next packet offered during TX waits, nothing lost or duplicated
    pa[0] = 32'h1948_0003; pa[1] = 32'hAAAA_0001; pa[2] = 32'hAAAA_0002;
    pb[0] = 32'hE2D0_0004; pb[1] = 32'hBBBB_0001;
    out_ready = 1'b0;
    send_pkt(pa, 3, 1'b1);
    fork
      send_pkt(pb, 2, 1'b1);
      begin
        repeat (5) begin
          @(posedge clk); #1;
          check("t6_tx_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("t6");
    check("t6_echo_cnt", 32'(echo_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
